// File: rtl/ledr_pattern_sequencer.sv
// ledr_pattern_sequencer: sole Avalon-MM master of the 10-bit LED PIO; arbitrates CPU LED writes against a rotate/blink/bounce pattern engine.
// Latency: an accepted reg-0 write strobes the PIO on the next cycle; an engine step strobes 1 cycle later, or 2 if a CPU write is pending.
// Backpressure: s_waitrequest holds a reg-0 write while the previous CPU value is still waiting for its PIO strobe; engine steps coalesce and are never stalled.
//
// Ports: clk/reset_n (async active-low); s_* CPU slave (2-bit address, zero-wait combinational read);
//        pio_* write-only master towards the LED PIO (address always 0, single-cycle write strobe).
// Optional: define LEDR_SEQ_IRQ_EN to add the irq output (cycle-complete interrupt) and STATUS bit LED_W+2.
module ledr_pattern_sequencer #(
   parameter int LED_W = 10,
   parameter int DIV_W = 24
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  s_address,
   input  logic        s_chipselect,
   input  logic        s_write_n,
   input  logic [31:0] s_writedata,
   output logic [31:0] s_readdata,
   output logic        s_waitrequest,
   output logic [1:0]  pio_address,
   output logic        pio_chipselect,
   output logic        pio_write_n,
   output logic [31:0] pio_writedata
`ifdef LEDR_SEQ_IRQ_EN
   ,
   output logic        irq
`endif
);

   // Bit 0 of the encoding is the PIO strobe, so pio_chipselect comes straight off a flop.
   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      WR_CPU = 2'b01,
      WR_ENG = 2'b11
   } state_t;

   localparam logic [1:0]       MODE_ROL    = 2'b00;
   localparam logic [1:0]       MODE_ROR    = 2'b01;
   localparam logic [1:0]       MODE_BLINK  = 2'b10;
   localparam logic [1:0]       MODE_BOUNCE = 2'b11;
   localparam logic [DIV_W-1:0] ONE_D       = DIV_W'(1);

   state_t           r_state, w_state_nxt;
   logic [LED_W-1:0] r_pattern, r_seed, r_shadow, w_step_pat;
   logic [DIV_W-1:0] r_period, r_cnt, w_last;
   logic [1:0]       r_mode;
   logic             r_run, r_dir, w_dir_step;
   logic             r_cpu_pend, r_eng_pend, w_cpu_pend_nxt, w_eng_pend_nxt;
   logic             w_wr, w_rd, w_wr_led, w_wr_led_acc, w_wr_ctrl, w_wr_period;
   logic             w_run_off, w_terminal, w_step, w_irq_bit;
   logic             w_unused_wdata;

   assign w_wr          = s_chipselect & ~s_write_n;
   assign w_rd          = s_chipselect & s_write_n;
   assign w_wr_led      = w_wr & (s_address == 2'd0);
   assign w_wr_led_acc  = w_wr_led & ~r_cpu_pend;
   assign w_wr_ctrl     = w_wr & (s_address == 2'd1);
   assign w_wr_period   = w_wr & (s_address == 2'd2);
   assign w_run_off     = w_wr_ctrl & ~s_writedata[0];
   assign s_waitrequest = w_wr_led & r_cpu_pend;
   assign w_unused_wdata = ^s_writedata;

   // PERIOD of 0 behaves as 1. A PERIOD write or a stop restarts the count and swallows that cycle's step.
   assign w_last     = (r_period == '0) ? '0 : r_period - ONE_D;
   assign w_terminal = r_run & (r_cnt == w_last);
   assign w_step     = w_terminal & ~w_wr_period & ~w_run_off;

   always_comb begin
      w_step_pat = r_pattern;
      w_dir_step = r_dir;
      case (r_mode)
         MODE_ROL:   w_step_pat = {r_pattern[LED_W-2:0], r_pattern[LED_W-1]};
         MODE_ROR:   w_step_pat = {r_pattern[0], r_pattern[LED_W-1:1]};
         MODE_BLINK: w_step_pat = (r_pattern == '0) ? r_seed : '0;
         default: begin
            // A lit end bit reflects before moving, so the light turns around instead of falling off.
            if (!r_dir) begin
               if (r_pattern[LED_W-1]) begin
                  w_dir_step = 1'b1;
                  w_step_pat = r_pattern >> 1;
               end else begin
                  w_step_pat = r_pattern << 1;
               end
            end else begin
               if (r_pattern[0]) begin
                  w_dir_step = 1'b0;
                  w_step_pat = r_pattern << 1;
               end else begin
                  w_step_pat = r_pattern >> 1;
               end
            end
         end
      endcase
   end

   // Next-state logic is the same from every state: serving a request clears its flag, and the
   // following state is chosen from the flags as they will stand next cycle (CPU first).
   // Using next-cycle flags is what lets a write or step strobe the PIO on the very next cycle.
   always_comb begin
      w_cpu_pend_nxt = r_cpu_pend;
      if (w_wr_led_acc)
         w_cpu_pend_nxt = 1'b1;
      else if (r_state == WR_CPU)
         w_cpu_pend_nxt = 1'b0;

      // A CPU write replaces the pattern, so any engine request it overtakes is stale.
      w_eng_pend_nxt = r_eng_pend;
      if (w_wr_led_acc || w_run_off)
         w_eng_pend_nxt = 1'b0;
      else if (w_step)
         w_eng_pend_nxt = 1'b1;
      else if (r_state == WR_ENG)
         w_eng_pend_nxt = 1'b0;

      w_state_nxt = IDLE;
      if (w_cpu_pend_nxt)
         w_state_nxt = WR_CPU;
      else if (w_eng_pend_nxt)
         w_state_nxt = WR_ENG;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= IDLE;
         r_cpu_pend <= 1'b0;
         r_eng_pend <= 1'b0;
         r_pattern  <= '0;
         r_seed     <= '0;
         r_shadow   <= '0;
         r_run      <= 1'b0;
         r_mode     <= MODE_ROL;
         r_dir      <= 1'b0;
         r_period   <= '0;
         r_cnt      <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_cpu_pend <= w_cpu_pend_nxt;
         r_eng_pend <= w_eng_pend_nxt;
         if (r_state != IDLE)
            r_shadow <= r_pattern;
         if (w_wr_led_acc) begin
            r_seed    <= s_writedata[LED_W-1:0];
            r_pattern <= s_writedata[LED_W-1:0];
         end else if (w_step) begin
            r_pattern <= w_step_pat;
            r_dir     <= w_dir_step;
         end
         if (w_wr_ctrl) begin
            r_run  <= s_writedata[0];
            r_mode <= s_writedata[2:1];
            if (s_writedata[2:1] == MODE_BOUNCE)
               r_dir <= 1'b0;
         end
         if (w_wr_period)
            r_period <= s_writedata[DIV_W-1:0];
         if (w_wr_period || w_run_off || !r_run || w_terminal)
            r_cnt <= '0;
         else
            r_cnt <= r_cnt + ONE_D;
      end
   end

`ifdef LEDR_SEQ_IRQ_EN
   logic r_irq, w_irq_set, w_irq_clr;

   // Cycle complete: the engine has brought the pattern back round to the seed.
   assign w_irq_set = (r_state == WR_ENG) && (r_pattern == r_seed);
   assign w_irq_clr = w_wr & (s_address == 2'd3) & s_writedata[LED_W+2];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         r_irq <= 1'b0;
      else if (w_irq_set)
         r_irq <= 1'b1;
      else if (w_irq_clr)
         r_irq <= 1'b0;
   end

   assign irq       = r_irq;
   assign w_irq_bit = r_irq;
`else
   assign w_irq_bit = 1'b0;
`endif

   always_comb begin
      s_readdata = '0;
      if (w_rd) begin
         case (s_address)
            2'd0:    s_readdata = 32'(r_shadow);
            2'd1:    s_readdata = {29'd0, r_mode, r_run};
            2'd2:    s_readdata = 32'(r_period);
            default: s_readdata = 32'({w_irq_bit, r_pattern, r_run, r_cpu_pend | r_eng_pend});
         endcase
      end
   end

   assign pio_address    = 2'b00;
   assign pio_chipselect = r_state[0];
   assign pio_write_n    = ~r_state[0];
   assign pio_writedata  = r_state[0] ? 32'(r_pattern) : 32'd0;

endmodule

// File: tb/tb_ledr_pattern_sequencer.sv
// tb_ledr_pattern_sequencer: checks ledr_pattern_sequencer against a pattern model built from rotation
// arithmetic and a bounce triangle wave; strobes are logged with their cycle index and compared afterwards.
// Covers reset, CPU strobes, backpressure, engine modes and timing, CPU/engine collision, async reset.
`timescale 1ns/1ps
module tb_ledr_pattern_sequencer;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [1:0]  s_address = 2'd0;
   logic        s_chipselect = 1'b0;
   logic        s_write_n = 1'b1;
   logic [31:0] s_writedata = 32'd0;
   logic [31:0] s_readdata;
   logic        s_waitrequest;
   logic [1:0]  pio_address;
   logic        pio_chipselect;
   logic        pio_write_n;
   logic [31:0] pio_writedata;
`ifdef LEDR_SEQ_IRQ_EN
   logic        irq;
`endif

   ledr_pattern_sequencer dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .s_address      (s_address),
      .s_chipselect   (s_chipselect),
      .s_write_n      (s_write_n),
      .s_writedata    (s_writedata),
      .s_readdata     (s_readdata),
      .s_waitrequest  (s_waitrequest),
      .pio_address    (pio_address),
      .pio_chipselect (pio_chipselect),
      .pio_write_n    (pio_write_n),
      .pio_writedata  (pio_writedata)
`ifdef LEDR_SEQ_IRQ_EN
      ,
      .irq            (irq)
`endif
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_pass = 0;
   int unsigned cyc = 0;
   int unsigned last_acc;
   int          last_waits;
   int unsigned st_cyc[$];
   logic [31:0] st_val[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
   endtask

   // Strobe log: every PIO write seen, tagged with the cycle it occupied.
   always @(negedge clk) begin
      if (reset_n && pio_chipselect) begin
         st_cyc.push_back(cyc);
         st_val.push_back(pio_writedata);
         chk("pio_ctl", {29'd0, pio_write_n, pio_address}, 32'd0);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got %0d checks expected completion", n_checks);
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
   task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
      s_chipselect = 1'b1;
      s_write_n    = 1'b0;
      s_address    = a;
      s_writedata  = d;
      last_waits   = 0;
      @(negedge clk);
      while (s_waitrequest && last_waits < 20) begin
         last_waits++;
         @(negedge clk);
      end
      chk("wr_wait_bound", 32'(s_waitrequest), 32'd0);
      last_acc = cyc;
      @(posedge clk);
      #1;
      s_chipselect = 1'b0;
      s_write_n    = 1'b1;
   endtask

   task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
      s_chipselect = 1'b1;
      s_write_n    = 1'b1;
      s_address    = a;
      @(negedge clk);
      d = s_readdata;
      @(posedge clk);
      #1;
      s_chipselect = 1'b0;
   endtask

   task automatic expect_strobe(input string tag, input int unsigned at, input logic [31:0] v);
      logic [31:0] got;
      got = 32'hFFFF_FFFF;
      foreach (st_cyc[i])
         if (st_cyc[i] == at) got = st_val[i];
      chk(tag, got, v);
   endtask

   function automatic logic [9:0] rotl(input logic [9:0] p, input int k);
      logic [19:0] d;
      d = {p, p} << k;
      return d[19:10];
   endfunction

   // Pattern after j engine steps starting from seed. Bounce assumes a one-hot seed and
   // walks a triangle wave of period 18 over bit positions 0..9.
   function automatic logic [9:0] model_step(input logic [1:0] mode, input logic [9:0] seed, input int j);
      int pos, u;
      pos = 0;
      for (int i = 0; i < 10; i++)
         if (seed[i]) pos = i;
      u = (pos + j) % 18;
      case (mode)
         2'd0:    return rotl(seed, j % 10);
         2'd1:    return rotl(seed, (10 - (j % 10)) % 10);
         2'd2:    return (j % 2 == 1) ? 10'd0 : seed;
         default: return 10'd1 << ((u <= 9) ? u : 18 - u);
      endcase
   endfunction

   task automatic run_engine(input logic [9:0] seed, input int per, input logic [1:0] mode,
                             input int nsteps, input int extra);
      int          eff, base, idx;
      int unsigned c, s;
      logic [31:0] rd;
      logic [9:0]  last_pat;
      eff = (per == 0) ? 1 : per;
      bus_wr(2'd0, 32'(seed));
      chk("seed_wait", 32'(last_waits), 32'd0);
      tick();
      tick();
      expect_strobe("seed_strobe", last_acc + 1, 32'(seed));
      bus_wr(2'd2, {8'hA5, 24'(per)});
      bus_rd(2'd2, rd);
      chk("period_rd", rd, 32'(per));
      base = st_cyc.size();
      bus_wr(2'd1, {29'd0, mode, 1'b1});
      c = last_acc;
      s = c + 32'(eff * nsteps + 1 + extra);
      while (cyc < s) tick();
      bus_wr(2'd1, {29'd0, mode, 1'b0});
      repeat (3) tick();
      chk("eng_count", 32'(st_cyc.size() - base), 32'(nsteps));
      for (int j = 1; j <= nsteps; j++) begin
         idx = base + j - 1;
         if (idx < st_cyc.size()) begin
            chk("eng_cyc", st_cyc[idx], c + 32'(eff * j + 1));
            chk("eng_val", st_val[idx], 32'(model_step(mode, seed, j)));
         end
      end
      last_pat = model_step(mode, seed, nsteps);
      bus_rd(2'd3, rd);
      chk("status_stop", rd, 32'({last_pat, 2'b00}));
      bus_rd(2'd0, rd);
      chk("shadow_stop", rd, 32'(last_pat));
      bus_rd(2'd1, rd);
      chk("ctrl_rd", rd, {29'd0, mode, 1'b0});
   endtask

   initial begin
      logic [31:0] rd;
      int unsigned a1, a2, w, c;
      logic [1:0]  m;
      int          per, eff, ns, ex;
      logic [9:0]  sd;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_cs", 32'(pio_chipselect), 32'd0);
      chk("rst_wn", 32'(pio_write_n), 32'd1);
      chk("rst_wdata", pio_writedata, 32'd0);
      chk("rst_addr", 32'(pio_address), 32'd0);
      chk("rst_wait", 32'(s_waitrequest), 32'd0);
      chk("rst_rdata", s_readdata, 32'd0);
      @(posedge clk);
      #1 reset_n = 1'b1;
      tick();
      bus_rd(2'd3, rd);
      chk("rst_status", rd, 32'd0);
      bus_rd(2'd2, rd);
      chk("rst_period", rd, 32'd0);

      // Single CPU write
      bus_wr(2'd0, 32'h155);
      chk("cpu_wait", 32'(last_waits), 32'd0);
      tick();
      expect_strobe("cpu_strobe", last_acc + 1, 32'h155);
      bus_rd(2'd0, rd);
      chk("cpu_shadow", rd, 32'h155);

      // Back-to-back CPU writes
      bus_wr(2'd0, 32'h001);
      a1 = last_acc;
      bus_wr(2'd0, 32'h002);
      a2 = last_acc;
      chk("b2b_waits", 32'(last_waits), 32'd1);
      chk("b2b_accept", a2, a1 + 2);
      tick();
      expect_strobe("b2b_first", a1 + 1, 32'h001);
      expect_strobe("b2b_second", a2 + 1, 32'h002);
      bus_rd(2'd3, rd);
      chk("b2b_status", rd, 32'h008);

      // Engine: rotate-left full cycle and bounce reflection
      run_engine(10'h001, 4, 2'd0, 10, 0);
      run_engine(10'h200, 1, 2'd3, 12, 0);

      // CPU write on an engine terminal cycle
      bus_wr(2'd0, 32'h001);
      bus_wr(2'd2, 32'd1);
      bus_wr(2'd1, 32'd1);
      repeat (5) tick();
      bus_wr(2'd0, 32'h0F0);
      w = last_acc;
      chk("coll_wait", 32'(last_waits), 32'd0);
      repeat (2) tick();
      bus_wr(2'd1, 32'd0);
      tick();
      expect_strobe("coll_cpu", w + 1, 32'h0F0);
      expect_strobe("coll_next", w + 2, 32'h1E0);

      // Randomized engine runs
      for (int it = 0; it < 10; it++) begin
         m   = 2'($urandom_range(0, 3));
         per = int'($urandom_range(0, 5));
         eff = (per == 0) ? 1 : per;
         ns  = int'($urandom_range(2, 12));
         ex  = int'($urandom_range(0, eff - 1));
         if (m == 2'd3)
            sd = 10'd1 << $urandom_range(0, 9);
         else
            sd = 10'($urandom_range(1, 1023));
         run_engine(sd, per, m, ns, ex);
      end

`ifdef LEDR_SEQ_IRQ_EN
      bus_wr(2'd0, 32'h001);
      bus_wr(2'd2, 32'd1);
      bus_wr(2'd1, 32'd1);
      c = last_acc;
      while (cyc < c + 10) tick();
      @(negedge clk);
      chk("irq_before", 32'(irq), 32'd0);
      tick();
      tick();
      bus_wr(2'd1, 32'd0);
      tick();
      chk("irq_set", 32'(irq), 32'd1);
      bus_rd(2'd3, rd);
      chk("irq_status", rd, 32'h1008);
      bus_wr(2'd3, 32'h1000);
      chk("irq_clr", 32'(irq), 32'd0);
`endif

      // Reset asserted in the middle of a strobe
      bus_wr(2'd0, 32'h003);
      bus_wr(2'd2, 32'd1);
      bus_wr(2'd1, 32'd1);
      repeat (3) tick();
      chk("pre_rst_cs", 32'(pio_chipselect), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      chk("arst_cs", 32'(pio_chipselect), 32'd0);
      chk("arst_wn", 32'(pio_write_n), 32'd1);
      @(posedge clk);
      #1 reset_n = 1'b1;
      tick();
      bus_rd(2'd1, rd);
      chk("arst_ctrl", rd, 32'd0);
      bus_rd(2'd3, rd);
      chk("arst_status", rd, 32'd0);
      bus_rd(2'd0, rd);
      chk("arst_shadow", rd, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
